// File: rtl/peak_counter_pkg.sv
// Shared definitions for the peak-counter readout path: FSM encodings and
// FIFO pointer sizing.
package peak_counter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_GATE  = 2'd2;
  localparam logic [1:0] ST_CAPT  = 2'd3;

  // One extra bit distinguishes full from empty when the indices match.
  function automatic int unsigned fifo_ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and a drop strobe for a push that
// arrives while full without a same-cycle pop.
module sync_fifo
  import peak_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned PW = fifo_ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the slot the push is about to use.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/gate_window_readout.sv
// Gate-window controller for the peak counter: clears and enables the counter
// for gate_len cycles, then queues {overflow, count} for the host reader.
module gate_window_readout
  import peak_counter_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH = 8,
  parameter int unsigned GATE_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [GATE_WIDTH-1:0] gate_len,
  output logic                  cnt_clr,
  output logic                  cnt_en,
  input  logic [CNTR_WIDTH-1:0] count_in,
  input  logic                  overflow_in,
  output logic                  rd_valid,
  output logic [CNTR_WIDTH:0]   rd_data,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  lost_window,
  input  logic                  clr_lost
);

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [GATE_WIDTH-1:0] timer;
  logic                  start_ok;
  logic                  push;
  logic                  drop;
  logic                  full;
  logic                  empty;

  assign start_ok = enable && (gate_len != '0);
  assign push     = (state == ST_CAPT);
  assign rd_valid = ~empty;

  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE:  next_state = start_ok ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: next_state = ST_GATE;
      ST_GATE:  next_state = (timer == '0) ? ST_CAPT : ST_GATE;
      ST_CAPT:  next_state = start_ok ? ST_CLEAR : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      cnt_clr <= 1'b0;
      cnt_en  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= next_state;
      cnt_clr <= (next_state == ST_CLEAR);
      cnt_en  <= (next_state == ST_GATE);
      busy    <= (next_state != ST_IDLE);
      if (state == ST_CLEAR)     timer <= gate_len - GATE_WIDTH'(1);
      else if (state == ST_GATE) timer <= timer - GATE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        lost_window <= 1'b0;
    else if (drop)     lost_window <= 1'b1;
    else if (clr_lost) lost_window <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (CNTR_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({overflow_in, count_in}),
    .pop     (rd_ready),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .drop    (drop)
  );

endmodule
